axi_wstream_gen: RTL and testbench

Synthetic AXI4 write-data stream source that sits directly upstream of the byte counter. It drives the monitored W channel (`valid`/`ready`/`strb`) with a programmed number of bytes as full beats plus one partial-strobe tail beat, using a deterministic byte pattern and an optional inter-beat gap. The counter's result can be checked against the generator's own `sent_bytes` total.

---
 rtl/axi_wstream_gen.sv | 126 ++++++++++++
 tb/tb_axi_wstream_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wstream_gen.sv
// rtl/axi_wstream_gen.sv - synthetic AXI4 W-channel source: programmed byte count as full beats plus a partial tail,
// deterministic byte pattern, optional inter-beat gap, running total of strobed bytes sent.
module axi_wstream_gen #(
  parameter int p_axi_data_width = 128,
  parameter int gap_width        = 8
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic                            start,
  input  logic [31:0]                     byte_count,
  input  logic [7:0]                      seed,
  input  logic [gap_width-1:0]            gap,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     sent_bytes,
  output logic [p_axi_data_width-1:0]     m_axi_wdata,
  output logic [p_axi_data_width/8-1:0]   m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready
);

  localparam int b = p_axi_data_width / 8;

  typedef enum logic [1:0] {st_idle, st_send, st_gap, st_fin} state_t;

  state_t               state_q, state_d;
  logic [31:0]          r_q;
  logic [31:0]          n_q;
  logic [7:0]           seed_q;
  logic [gap_width-1:0] gap_q;
  logic [gap_width-1:0] gap_cnt_q;

  logic        handshake;
  logic        last_beat;
  logic [31:0] take;
  logic [7:0]  lane_base;

  assign last_beat = (r_q <= 32'(b));
  assign handshake = (state_q == st_send) && m_axi_wready;
  assign take      = last_beat ? r_q : 32'(b);
  // Only the low 8 bits of n*B matter, so the 32-bit product is simply truncated.
  assign lane_base = seed_q + 8'(n_q * 32'(b));

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: begin
        if (start) begin
          state_d = (byte_count == 32'd0) ? st_fin : st_send;
        end
      end
      st_send: begin
        if (m_axi_wready) begin
          if (last_beat) begin
            state_d = st_fin;
          end else if (gap_q != '0) begin
            state_d = st_gap;
          end else begin
            state_d = st_send;
          end
        end
      end
      st_gap: begin
        if (gap_cnt_q == '0) begin
          state_d = st_send;
        end
      end
      st_fin:  state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  always_comb begin
    busy         = (state_q != st_idle);
    done         = (state_q == st_fin);
    m_axi_wvalid = (state_q == st_send);
    m_axi_wdata  = '0;
    m_axi_wstrb  = '0;
    m_axi_wlast  = 1'b0;
    if (state_q == st_send) begin
      for (int i = 0; i < b; i++) begin
        m_axi_wdata[i*8 +: 8] = lane_base + 8'(i);
        m_axi_wstrb[i]        = (32'(i) < r_q);
      end
      m_axi_wlast = last_beat;
    end
  end

  // Gap counter is loaded with gap-1 so GAP lasts exactly gap cycles.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_q        <= '0;
      n_q        <= '0;
      seed_q     <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      sent_bytes <= '0;
    end else begin
      if ((state_q == st_idle) && start) begin
        r_q        <= byte_count;
        n_q        <= '0;
        seed_q     <= seed;
        gap_q      <= gap;
        sent_bytes <= '0;
      end
      if (handshake) begin
        sent_bytes <= sent_bytes + take;
        r_q        <= r_q - take;
        n_q        <= n_q + 32'd1;
        gap_cnt_q  <= gap_q - gap_width'(1);
      end else if ((state_q == st_gap) && (gap_cnt_q != '0)) begin
        gap_cnt_q  <= gap_cnt_q - gap_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_wstream_gen.sv
// tb/tb_axi_wstream_gen.sv - bench for axi_wstream_gen: beat-queue reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_axi_wstream_gen;

  logic         clk;
  logic         srst;
  logic         start;
  logic [31:0]  byte_count;
  logic [7:0]   seed;
  logic [7:0]   gap;
  logic         busy;
  logic         done;
  logic [31:0]  sent_bytes;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready;

  axi_wstream_gen #(.p_axi_data_width(128), .gap_width(8)) dut (
    .clk(clk), .srst(srst), .start(start), .byte_count(byte_count), .seed(seed), .gap(gap),
    .busy(busy), .done(done), .sent_bytes(sent_bytes),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of beats still to send, idle cycles before the next beat, pending done.
  typedef struct {
    logic [127:0] d;
    logic [15:0]  s;
    logic         l;
  } beat_t;

  beat_t       mq[$];
  int          wait_n = 0;
  int          gap_m = 0;
  bit          done_pend = 0;
  logic [31:0] sent_m = 0;
  bit          chk_en = 0;
  bit          after_rst = 0;
  int          cyc = 0;

  logic [127:0] hs_data[$];
  logic [15:0]  hs_strb[$];
  logic         hs_last[$];
  int           hs_cyc[$];
  int           acc_cyc = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;

  function automatic bit m_busy();
    return (mq.size() > 0) || done_pend;
  endfunction

  function automatic void build(input int unsigned cnt, input logic [7:0] sd);
    beat_t bt;
    int    rem;
    for (int j = 0; j * 16 < int'(cnt); j++) begin
      rem = int'(cnt) - j * 16;
      for (int i = 0; i < 16; i++) begin
        bt.d[i*8 +: 8] = 8'((int'(sd) + j * 16 + i) % 256);
        bt.s[i]        = (i < rem);
      end
      bt.l = (rem <= 16);
      mq.push_back(bt);
    end
  endfunction

  always @(negedge clk) begin
    bit    exp_valid;
    beat_t bt;
    exp_valid = (mq.size() > 0) && (wait_n == 0);
    if (chk_en) begin
      check("busy", busy, m_busy());
      check("done", done, done_pend);
      check("wvalid", m_axi_wvalid, exp_valid);
      check("sent_bytes", sent_bytes, sent_m);
      if (exp_valid) begin
        bt = mq[0];
        check("wdata", m_axi_wdata, bt.d);
        check("wstrb", m_axi_wstrb, bt.s);
        check("wlast", m_axi_wlast, bt.l);
      end
      if (after_rst) begin
        check("rst_wdata", m_axi_wdata, 0);
        check("rst_wstrb", m_axi_wstrb, 0);
        check("rst_wlast", m_axi_wlast, 0);
      end
    end
    after_rst = srst;
    if (chk_en && !srst) begin
      if (m_axi_wvalid && m_axi_wready) begin
        hs_data.push_back(m_axi_wdata);
        hs_strb.push_back(m_axi_wstrb);
        hs_last.push_back(m_axi_wlast);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
    if (srst) begin
      mq.delete();
      wait_n    = 0;
      done_pend = 0;
      sent_m    = 0;
      chk_en    = 1;
    end else if (done_pend) begin
      done_pend = 0;
    end else if (mq.size() > 0) begin
      if (wait_n > 0) begin
        wait_n--;
      end else if (m_axi_wready) begin
        bt = mq.pop_front();
        sent_m += 32'($countones(bt.s));
        if (bt.l) done_pend = 1;
        else wait_n = gap_m;
      end
    end else if (start) begin
      acc_cyc = cyc;
      sent_m  = 0;
      gap_m   = int'(gap);
      build(byte_count, seed);
      wait_n  = 0;
      if (mq.size() == 0) done_pend = 1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    hs_data.delete();
    hs_strb.delete();
    hs_last.delete();
    hs_cyc.delete();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_busy() && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (m_busy()) begin
      errors++;
      $display("FAIL wait_idle: transfer still running after %0d cycles", budget);
    end
  endtask

  // Inputs are scrambled right after the start pulse to show they were latched.
  task automatic go(input int unsigned cnt, input logic [7:0] sd, input logic [7:0] gp);
    clr_log();
    byte_count = cnt;
    seed       = sd;
    gap        = gp;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    byte_count = $urandom;
    seed       = 8'($urandom);
    gap        = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int k;
    srst = 1'b1; start = 1'b0; byte_count = '0; seed = '0; gap = '0; m_axi_wready = 1'b1;
    tick(); tick();
    srst = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_sent", sent_bytes, 0);

    // Full beats
    go(64, 8'h00, 8'd0);
    wait_idle(100);
    check("full_nbeats", hs_cyc.size(), 4);
    check("full_first_lat", hs_cyc[0] - acc_cyc, 1);
    check("full_last_cyc", hs_cyc[3] - acc_cyc, 4);
    check("full_done_cyc", done_cyc - acc_cyc, 5);
    check("full_b1_lane0", hs_data[1][7:0], 8'h10);
    check("full_strb0", hs_strb[0], 16'hFFFF);
    check("full_last2", hs_last[2], 0);
    check("full_last3", hs_last[3], 1);
    check("full_sent", sent_bytes, 64);

    // Partial tail with lane wrap
    go(37, 8'hF8, 8'd0);
    wait_idle(100);
    check("tail_nbeats", hs_cyc.size(), 3);
    check("tail_strb1", hs_strb[1], 16'hFFFF);
    check("tail_strb2", hs_strb[2], 16'h001F);
    check("tail_b0_lane8", hs_data[0][71:64], 8'h00);
    check("tail_sent", sent_bytes, 37);

    // Gap and backpressure
    m_axi_wready = 1'b0;
    go(32, 8'h40, 8'd3);
    repeat (5) tick();
    m_axi_wready = 1'b1;
    wait_idle(100);
    check("gap_hs0_cyc", hs_cyc[0] - acc_cyc, 6);
    check("gap_hs1_cyc", hs_cyc[1] - hs_cyc[0], 4);
    check("gap_sent", sent_bytes, 32);

    // Zero length
    dc = done_cnt;
    go(0, 8'h11, 8'd0);
    wait_idle(100);
    check("zero_done_cyc", done_cyc - acc_cyc, 1);
    check("zero_done_cnt", done_cnt - dc, 1);
    check("zero_nbeats", hs_cyc.size(), 0);

    // Ignored start during transfer
    go(64, 8'h22, 8'd1);
    tick();
    byte_count = 16; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(100);
    check("ign_nbeats", hs_cyc.size(), 4);
    check("ign_sent", sent_bytes, 64);

    // Reset mid-transfer
    dc = done_cnt;
    go(64, 8'h33, 8'd0);
    k = 0;
    while (hs_cyc.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    check("rst_reach_beat1", hs_cyc.size(), 2);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    repeat (3) tick();
    check("rst_no_done", done_cnt - dc, 0);
    check("rst_sent_zero", sent_bytes, 0);
    go(16, 8'h44, 8'd0);
    wait_idle(100);
    check("rst_new_nbeats", hs_cyc.size(), 1);
    check("rst_new_sent", sent_bytes, 16);

    // Single byte
    go(1, 8'h5A, 8'd0);
    wait_idle(100);
    check("one_strb", hs_strb[0], 16'h0001);
    check("one_last", hs_last[0], 1);
    check("one_lane0", hs_data[0][7:0], 8'h5A);
    check("one_done_cyc", done_cyc - acc_cyc, 2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      m_axi_wready = ($urandom_range(0, 3) != 0);
      srst         = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 7) == 0);
      byte_count   = $urandom_range(0, 80);
      seed         = 8'($urandom);
      gap          = 8'($urandom_range(0, 3));
      tick();
    end
    srst = 1'b0; start = 1'b0; m_axi_wready = 1'b1;
    wait_idle(2000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
